// File: rtl/reg_bank_write_port.sv
// 16 x WIDTH register bank, write side: one write-back per cycle, R15 doubles
// as the program counter, and a per-register pending scoreboard flags
// registers that still have a reserved write outstanding.
module reg_bank_write_port #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] PC_RESET = '0,
  parameter int               PC_STEP  = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             we,
  input  logic [3:0]       wa,
  input  logic [WIDTH-1:0] wd,
  input  logic             pc_en,
  input  logic             rsv_en,
  input  logic [3:0]       rsv_addr,
  output logic [WIDTH-1:0] R0,
  output logic [WIDTH-1:0] R1,
  output logic [WIDTH-1:0] R2,
  output logic [WIDTH-1:0] R3,
  output logic [WIDTH-1:0] R4,
  output logic [WIDTH-1:0] R5,
  output logic [WIDTH-1:0] R6,
  output logic [WIDTH-1:0] R7,
  output logic [WIDTH-1:0] R8,
  output logic [WIDTH-1:0] R9,
  output logic [WIDTH-1:0] R10,
  output logic [WIDTH-1:0] R11,
  output logic [WIDTH-1:0] R12,
  output logic [WIDTH-1:0] R13,
  output logic [WIDTH-1:0] R14,
  output logic [WIDTH-1:0] R15,
  output logic [15:0]      pending,
  output logic             busy_err
);

  localparam int               PC_IDX = 15;
  localparam logic [WIDTH-1:0] PC_INC = WIDTH'(PC_STEP);

  logic [WIDTH-1:0] regs [16];
  logic [15:0]      wr_sel;
  logic [15:0]      rsv_sel;

  // One-hot decode of the write-back and reservation addresses.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    wr_sel  = '0;
    rsv_sel = '0;
    if (we)     wr_sel[wa]        = 1'b1;
    if (rsv_en) rsv_sel[rsv_addr] = 1'b1;
  end

  // Register storage, PC update, scoreboard and collision flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the bank is built from flops, not a RAM macro, so every entry is reset explicitly.
      for (int i = 0; i < PC_IDX; i++) regs[i] <= '0;
      regs[PC_IDX] <= PC_RESET;
      pending      <= '0;
      busy_err     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
      for (int i = 0; i < PC_IDX; i++) begin
        if (wr_sel[i]) regs[i] <= wd;
      end
      // An explicit write-back to the PC beats the auto-increment.
      if (wr_sel[PC_IDX])  regs[PC_IDX] <= wd;
      else if (pc_en)      regs[PC_IDX] <= regs[PC_IDX] + PC_INC;
      // A new reservation wins over completion of the old write.
      pending  <= rsv_sel | (pending & ~wr_sel);
      busy_err <= rsv_en && pending[rsv_addr] && !(we && (wa == rsv_addr));
    end
  end

  assign R0  = regs[0];
  assign R1  = regs[1];
  assign R2  = regs[2];
  assign R3  = regs[3];
  assign R4  = regs[4];
  assign R5  = regs[5];
  assign R6  = regs[6];
  assign R7  = regs[7];
  assign R8  = regs[8];
  assign R9  = regs[9];
  assign R10 = regs[10];
  assign R11 = regs[11];
  assign R12 = regs[12];
  assign R13 = regs[13];
  assign R14 = regs[14];
  assign R15 = regs[15];

endmodule

// File: tb/tb_reg_bank_write_port.sv
// Directed, table-driven bench for reg_bank_write_port with PC_RESET = 0x100.
module tb_reg_bank_write_port;

  logic        clk;
  logic        reset_n;
  logic        we;
  logic [3:0]  wa;
  logic [31:0] wd;
  logic        pc_en;
  logic        rsv_en;
  logic [3:0]  rsv_addr;
  wire  [31:0] r [16];
  wire  [15:0] pending;
  wire         busy_err;

  int n_checks = 0;
  int n_pass   = 0;

  reg_bank_write_port #(
    .WIDTH(32), .PC_RESET(32'h0000_0100), .PC_STEP(4)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .we(we), .wa(wa), .wd(wd),
    .pc_en(pc_en), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .R0(r[0]),   .R1(r[1]),   .R2(r[2]),   .R3(r[3]),
    .R4(r[4]),   .R5(r[5]),   .R6(r[6]),   .R7(r[7]),
    .R8(r[8]),   .R9(r[9]),   .R10(r[10]), .R11(r[11]),
    .R12(r[12]), .R13(r[13]), .R14(r[14]), .R15(r[15]),
    .pending(pending), .busy_err(busy_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic        pc_en;
    logic        rsv_en;
    logic [3:0]  rsv_addr;
    int          idx_a;
    logic [31:0] val_a;
    int          idx_b;
    logic [31:0] val_b;
    logic [15:0] pend;
    logic        busy;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic add(input logic w, input logic [3:0] a, input logic [31:0] d,
                     input logic pc, input logic rv, input logic [3:0] ra,
                     input int ia, input logic [31:0] va, input int ib, input logic [31:0] vb,
                     input logic [15:0] pn, input logic bz);
    vec_t v;
    v.we = w; v.wa = a; v.wd = d; v.pc_en = pc; v.rsv_en = rv; v.rsv_addr = ra;
    v.idx_a = ia; v.val_a = va; v.idx_b = ib; v.val_b = vb; v.pend = pn; v.busy = bz;
    vecs.push_back(v);
  endtask

  task automatic idle_inputs();
    we = 1'b0; wa = '0; wd = '0; pc_en = 1'b0; rsv_en = 1'b0; rsv_addr = '0;
  endtask

  // Advance one rising edge and sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ---- vector table (state after reset release: R0-R14 = 0, R15 = 0x100) ----
    add(0, 0, 0, 1, 0, 0, 15, 32'h104, 0, 32'h0, 16'h0, 0);
    add(0, 0, 0, 1, 0, 0, 15, 32'h108, 0, 32'h0, 16'h0, 0);
    add(0, 0, 0, 1, 0, 0, 15, 32'h10C, 0, 32'h0, 16'h0, 0);
    for (int i = 0; i < 15; i++) begin
      if (i < 14)
        add(1, 4'(i), 32'hA5A5_0000 + i, 0, 0, 0, i, 32'hA5A5_0000 + i, i + 1, 32'h0, 16'h0, 0);
      else
        add(1, 4'(i), 32'hA5A5_0000 + i, 0, 0, 0, i, 32'hA5A5_0000 + i, 15, 32'h10C, 16'h0, 0);
    end
    add(1, 15, 32'h0000_2000, 0, 0, 0, 15, 32'h2000, 14, 32'hA5A5_000E, 16'h0, 0);
    add(1, 15, 32'h0000_0040, 1, 0, 0, 15, 32'h40, 0, 32'hA5A5_0000, 16'h0, 0);
    add(1, 15, 32'hFFFF_FFFC, 0, 0, 0, 15, 32'hFFFF_FFFC, 0, 32'hA5A5_0000, 16'h0, 0);
    add(0, 0, 0, 1, 0, 0, 15, 32'h0, 0, 32'hA5A5_0000, 16'h0, 0);
    add(0, 0, 0, 0, 1, 3, 3, 32'hA5A5_0003, 15, 32'h0, 16'h0008, 0);
    add(1, 3, 32'h1111_1111, 0, 1, 3, 3, 32'h1111_1111, 15, 32'h0, 16'h0008, 0);
    add(1, 3, 32'h2222_2222, 0, 0, 0, 3, 32'h2222_2222, 15, 32'h0, 16'h0000, 0);
    add(0, 0, 0, 0, 1, 7, 7, 32'hA5A5_0007, 15, 32'h0, 16'h0080, 0);
    add(0, 0, 0, 0, 1, 7, 7, 32'hA5A5_0007, 15, 32'h0, 16'h0080, 1);
    add(0, 0, 0, 0, 0, 0, 7, 32'hA5A5_0007, 15, 32'h0, 16'h0080, 0);
    add(0, 0, 0, 0, 1, 5, 5, 32'hA5A5_0005, 15, 32'h0, 16'h00A0, 0);

    // ---- asynchronous reset between clock edges ----
    reset_n = 1'b1;
    idle_inputs();
    #2 reset_n = 1'b0;
    #1;
    for (int i = 0; i < 15; i++) check($sformatf("reset R%0d", i), r[i], 32'h0);
    check("reset R15", r[15], 32'h100);
    check("reset pending", 32'(pending), 32'h0);
    check("reset busy_err", 32'(busy_err), 32'h0);
    step();
    reset_n = 1'b1;

    // ---- table-driven vectors ----
    foreach (vecs[k]) begin
      we = vecs[k].we; wa = vecs[k].wa; wd = vecs[k].wd; pc_en = vecs[k].pc_en;
      rsv_en = vecs[k].rsv_en; rsv_addr = vecs[k].rsv_addr;
      step();
      check($sformatf("v%0d R%0d", k, vecs[k].idx_a), r[vecs[k].idx_a], vecs[k].val_a);
      check($sformatf("v%0d R%0d", k, vecs[k].idx_b), r[vecs[k].idx_b], vecs[k].val_b);
      check($sformatf("v%0d pending", k), 32'(pending), 32'(vecs[k].pend));
      check($sformatf("v%0d busy_err", k), 32'(busy_err), 32'(vecs[k].busy));
    end

    // ---- sweep result: every decoded register kept its own value ----
    idle_inputs();
    #1;
    for (int i = 0; i < 15; i++) begin
      if (i == 3)      check("sweep R3", r[i], 32'h2222_2222);
      else             check($sformatf("sweep R%0d", i), r[i], 32'hA5A5_0000 + i);
    end

    // ---- reset mid-operation with R5 pending and a write in flight ----
    we = 1'b1; wa = 4'd5; wd = 32'hDEAD_BEEF;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrst R5", r[5], 32'h0);
    check("midrst pending", 32'(pending), 32'h0);
    check("midrst R15", r[15], 32'h100);
    step();
    check("midrst held R5", r[5], 32'h0);
    reset_n = 1'b1;
    idle_inputs();
    step();
    step();
    check("post-rst R5", r[5], 32'h0);
    check("post-rst pending", 32'(pending), 32'h0);
    check("post-rst R15", r[15], 32'h100);
    we = 1'b1; wa = 4'd5; wd = 32'h1234_5678;
    step();
    check("post-rst write R5", r[5], 32'h1234_5678);
    check("post-rst write R4", r[4], 32'h0);
    idle_inputs();
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reg_bank_write_port.md
Name: reg_bank_write_port

Overview:
- 16-entry × 32-bit register bank. This is the write/storage side of the register-file read path.
- It accepts one write-back per cycle, decodes a 4-bit destination address into 16 load enables, and holds the registers.
- It presents all 16 register values in parallel to the 16:1 read multiplexers.
- R15 is the program counter: it auto-increments when pc_en is asserted.
- A per-register pending scoreboard flags registers with an outstanding write, for hazard detection in the pipeline.

Parameters:
- WIDTH, 32, data width of every register.
- PC_RESET, 32'h0000_0000, R15 value after reset.
- PC_STEP, 4, R15 increment per pc_en cycle.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- we  input  1  write-back enable.
- wa  input  4  write-back destination address.
- wd  input  WIDTH  write-back data.
- pc_en  input  1  increment R15 by PC_STEP this cycle.
- rsv_en  input  1  mark register rsv_addr pending.
- rsv_addr  input  4  register to reserve.
- R0 … R15  output  WIDTH each  current register contents (R15 = PC).
- pending  output  16  bit i = 1 while Ri has an outstanding reserved write.
- busy_err  output  1  one-cycle pulse: reservation of an already-pending register.

Behaviour:
Reset:
- reset_n = 0 asynchronously forces R0–R14 = 0, R15 = PC_RESET, pending = 0, busy_err = 0.
- This holds regardless of clk.
- Reset asserted mid-operation discards any write/reserve in that cycle.
- The first update after release happens at the first rising clk with reset_n = 1.

Write decode:
- On a rising clk with we = 1, one-hot decode of wa selects register Rwa; Rwa <= wd.
- All other registers hold.
- Latency: the new value is visible on Rwa outputs immediately after that edge (1-cycle write). There is no write-to-read bypass; readers see the old value during the write cycle.

R15 / PC:
- pc_en = 1 and not (we && wa == 15) → R15 <= R15 + PC_STEP, modulo 2^WIDTH. 32'hFFFF_FFFC + 4 wraps to 0.
- we = 1 with wa = 15 → R15 <= wd, whether or not pc_en is set. Explicit write beats increment.
- Neither condition → R15 holds.

Pending scoreboard, per bit i, on each rising clk:
- set_i = rsv_en && rsv_addr == i.
- clr_i = we && wa == i.
- set_i && clr_i → pending[i] stays 1. A new reservation takes precedence over the completion of the old one.
- set_i only → pending[i] <= 1.
- clr_i only → pending[i] <= 0.
- Neither → hold.
- A write to a non-pending register is legal: the data is written and pending stays 0.

busy_err:
- Registered. busy_err <= rsv_en && pending[rsv_addr] && !(we && wa == rsv_addr).
- It is otherwise 0 and lasts exactly one cycle per offending request.
- The reservation still takes effect; pending stays 1.

General:
- All outputs are registered; there are no combinational paths from inputs to outputs.
- R0 is an ordinary writable register, not hard-wired to zero.

Test Plan:
- Reset value check:
  - Stimulus: drive reset_n = 0 between clocks, with PC_RESET = 32'h0000_0100.
  - Required response: R0–R14 = 0 and R15 = 32'h100 immediately, without waiting for a clock edge; pending = 16'h0000.
  - Stimulus: release reset, then pc_en = 1 for 3 cycles.
  - Required response: R15 = 32'h10C.
- Decode sweep:
  - Stimulus: for wa = 0..14 write wd = 32'hA5A5_0000 + wa, one per cycle.
  - Required response: each Ri = 32'hA5A5_000i after its edge; all other registers unchanged.
  - Stimulus: finally write wa = 15, wd = 32'h0000_2000.
  - Required response: R15 = 32'h2000.
- PC collision and wrap:
  - Stimulus: pc_en = 1, we = 1, wa = 15, wd = 32'h0000_0040.
  - Required response: R15 = 32'h40, not old value + 4.
  - Stimulus: write wd = 32'hFFFF_FFFC, then one pc_en cycle.
  - Required response: R15 = 32'h0000_0000.
- Scoreboard sequence:
  - Stimulus: reserve R3.
  - Required response: pending = 16'h0008.
  - Stimulus: next cycle, simultaneous we to R3 and reserve R3.
  - Required response: pending stays 16'h0008 and R3 takes the new data.
  - Stimulus: then a plain write to R3.
  - Required response: pending = 16'h0000.
- busy_err:
  - Stimulus: reserve R7 twice in consecutive cycles, with no write in between.
  - Required response: busy_err high for exactly the one cycle following the second edge; pending[7] = 1.
- Reset mid-operation:
  - Stimulus: assert reset_n = 0 in the same cycle as we = 1, wa = 5, wd = 32'hDEAD_BEEF with R5 pending.
  - Required response: R5 = 0 and pending = 0; no write occurs after release until a new we.
